// File: rtl/vec_chunk_unpacker.sv
// vec_chunk_unpacker: pops WIDTH-bit words from a first-word fall-through FIFO
// and streams them out as CHUNK_W-bit chunks, lowest chunk first, over valid/ready.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_EMPTY | no word held, o_valid low, pops as soon as FIFO has data
//   ST_FULL  | word held in hold_q, chunk idx_q presented with o_valid high
module vec_chunk_unpacker #(
   parameter int WIDTH   = 248,
   parameter int CHUNK_W = 31,
   parameter int CNT_W   = 16,
   localparam int NUM_CHUNKS = WIDTH / CHUNK_W,
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   i_fifo_data,
   input  logic               i_fifo_empty,
   output logic               o_fifo_read,
   input  logic               i_flush,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [CHUNK_W-1:0] o_data,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_last,
   output logic [CNT_W-1:0]   o_words
);

   if (WIDTH % CHUNK_W != 0) begin : g_bad_width
      $error("vec_chunk_unpacker: WIDTH must be a multiple of CHUNK_W");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   words_q, words_d;
   logic               acc, done, pop;
   logic [CHUNK_W-1:0] data_sel;

   // valid is purely registered, so i_ready never reaches o_valid combinationally
   assign o_valid = (state_q == ST_FULL);
   assign acc     = o_valid && i_ready;
   assign done    = acc && (idx_q == LAST_IDX);
   assign pop     = !rst && !i_flush && !i_fifo_empty && ((state_q == ST_EMPTY) || done);

   assign o_fifo_read = pop;
   assign o_idx       = idx_q;
   assign o_last      = o_valid && (idx_q == LAST_IDX);
   assign o_words     = words_q;
   assign o_data      = data_sel;

   // chunk select out of the held word
   always_comb begin
      data_sel = '0;
      for (int k = 0; k < NUM_CHUNKS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            data_sel = hold_q[k*CHUNK_W +: CHUNK_W];
         end
      end
   end

   // next-state: flush beats pop and accept; a pop on the last accept reloads with no bubble
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      words_d = words_q;
      if (i_flush) begin
         state_d = ST_EMPTY;
         idx_d   = '0;
      end else begin
         if (done) begin
            words_d = words_q + CNT_W'(1);
         end
         if (pop) begin
            hold_d  = i_fifo_data;
            idx_d   = '0;
            state_d = ST_FULL;
         end else if (done) begin
            state_d = ST_EMPTY;
            idx_d   = '0;
         end else if (acc) begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   // state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         hold_q  <= '0;
         idx_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         words_q <= words_d;
      end
   end

endmodule

// File: tb/tb_vec_chunk_unpacker.sv
// Bench for vec_chunk_unpacker: directed table, corner sequences, random traffic
// against a word/chunk-level reference model and a queue-based FIFO.
module tb_vec_chunk_unpacker;

   localparam int W  = 248;
   localparam int CW = 31;
   localparam int NC = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  i_fifo_data = '0;
   logic          i_fifo_empty = 1'b1;
   logic          i_flush = 1'b0;
   logic          i_ready = 1'b0;
   logic          o_fifo_read, o_valid, o_last;
   logic [CW-1:0] o_data;
   logic [2:0]    o_idx;
   logic [15:0]   o_words;
   logic          o_fifo_read2, o_valid2, o_last2;
   logic [CW-1:0] o_data2;
   logic [2:0]    o_idx2;
   logic [1:0]    o_words2;

   vec_chunk_unpacker dut (
      .clk(clk), .rst(rst), .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
      .o_fifo_read(o_fifo_read), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_idx(o_idx), .o_last(o_last), .o_words(o_words));

   vec_chunk_unpacker #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
      .o_fifo_read(o_fifo_read2), .i_flush(i_flush), .o_valid(o_valid2), .i_ready(i_ready),
      .o_data(o_data2), .o_idx(o_idx2), .o_last(o_last2), .o_words(o_words2));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // FIFO contents and reference model state
   logic [W-1:0] q[$];
   bit           m_have;
   logic [W-1:0] m_word;
   int           m_k;
   int           m_words;
   bit           e_done, e_read;

   typedef struct {
      bit          rdy;
      bit          ev;
      int          eidx;
      bit          elast;
      bit          eread;
      logic [30:0] edata;
      int          ewords;
   } vec_t;
   vec_t tbl[18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] mkword(input int base);
      logic [W-1:0] w;
      w = '0;
      for (int k = 0; k < NC; k++) w[k*CW +: CW] = 31'(base + k);
      return w;
   endfunction

   function automatic logic [W-1:0] rndword();
      logic [W-1:0] w;
      w = '0;
      for (int k = 0; k < NC; k++) w[k*CW +: CW] = 31'($urandom);
      return w;
   endfunction

   task automatic drive(input bit r, input bit rdy, input bit fl);
      rst          = r;
      i_ready      = rdy;
      i_flush      = fl;
      i_fifo_empty = (q.size() == 0);
      i_fifo_data  = (q.size() != 0) ? q[0] : '0;
   endtask

   // expected outputs for this cycle, taken from the word-level model
   task automatic check_model();
      logic [CW-1:0] ed;
      e_done = m_have && (m_k == NC - 1) && i_ready;
      e_read = !rst && !i_flush && (q.size() != 0) && (!m_have || e_done);
      chk("valid", {63'd0, o_valid}, {63'd0, m_have});
      chk("idx", {61'd0, o_idx}, 64'(m_k));
      chk("last", {63'd0, o_last}, {63'd0, (m_have && m_k == NC - 1)});
      chk("fifo_read", {63'd0, o_fifo_read}, {63'd0, e_read});
      chk("words", {48'd0, o_words}, 64'(m_words % 65536));
      chk("words_cnt2", {62'd0, o_words2}, 64'(m_words % 4));
      if (m_have) begin
         ed = m_word[m_k*CW +: CW];
         chk("data", {33'd0, o_data}, {33'd0, ed});
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      if (rst) begin
         m_have = 0; m_k = 0; m_words = 0; m_word = '0;
      end else if (i_flush) begin
         m_have = 0; m_k = 0;
      end else begin
         if (e_done) m_words++;
         if (e_read) begin
            m_word = q.pop_front();
            m_have = 1;
            m_k    = 0;
         end else if (e_done) begin
            m_have = 0; m_k = 0;
         end else if (m_have && i_ready) begin
            m_k++;
         end
      end
   endtask

   task automatic step(input bit r, input bit rdy, input bit fl);
      drive(r, rdy, fl);
      @(negedge clk);
      check_model();
      advance();
   endtask

   int            saved_words;
   int            seq[$];
   int            last_w;
   logic [W-1:0]  nxt;

   initial begin
      // directed table: word A chunks 1..8 then word B chunks 17..24, ready held high
      tbl[0] = '{1, 0, 0, 0, 1, 31'd0, 0};
      for (int k = 0; k < NC; k++) begin
         tbl[1+k] = '{1, 1, k, (k == 7), (k == 7), 31'(1 + k), 0};
         tbl[9+k] = '{1, 1, k, (k == 7), 0, 31'(17 + k), 1};
      end
      tbl[17] = '{1, 0, 0, 0, 0, 31'd0, 2};

      m_have = 0; m_k = 0; m_words = 0; m_word = '0;
      e_done = 0; e_read = 0;

      // reset
      drive(1, 0, 0);
      advance();
      step(1, 0, 0);
      drive(0, 1, 0);
      @(negedge clk);
      check_model();
      chk("rst_data", {33'd0, o_data}, 64'd0);
      advance();

      // tests 1 and 2: single word, then two back-to-back words
      q.push_back(mkword(1));
      q.push_back(mkword(17));
      for (int i = 0; i < 18; i++) begin
         drive(0, tbl[i].rdy, 0);
         @(negedge clk);
         chk("tbl_valid", {63'd0, o_valid}, {63'd0, tbl[i].ev});
         chk("tbl_idx", {61'd0, o_idx}, 64'(tbl[i].eidx));
         chk("tbl_last", {63'd0, o_last}, {63'd0, tbl[i].elast});
         chk("tbl_read", {63'd0, o_fifo_read}, {63'd0, tbl[i].eread});
         chk("tbl_words", {48'd0, o_words}, 64'(tbl[i].ewords));
         if (tbl[i].ev) chk("tbl_data", {33'd0, o_data}, {33'd0, tbl[i].edata});
         check_model();
         advance();
      end

      // test 3: ready pattern 1,0,0,1
      q.push_back(mkword(100));
      for (int i = 0; i < 40; i++) step(0, (i % 4 == 0) || (i % 4 == 3), 0);

      // test 4: flush at idx 3 with a second word queued
      q.push_back(mkword(200));
      q.push_back(mkword(300));
      for (int i = 0; i < 20 && !(m_have && m_k == 3); i++) step(0, 1, 0);
      chk("flush_reach_idx3", 64'(m_k), 64'd3);
      saved_words = m_words;
      step(0, 1, 1);
      drive(0, 1, 0);
      @(negedge clk);
      check_model();
      chk("flush_valid_low", {63'd0, o_valid}, 64'd0);
      chk("flush_pop_after", {63'd0, o_fifo_read}, 64'd1);
      advance();
      drive(0, 1, 0);
      @(negedge clk);
      check_model();
      chk("flush_next_idx0", {61'd0, o_idx}, 64'd0);
      chk("flush_next_data", {33'd0, o_data}, 64'd300);
      chk("flush_words_kept", {48'd0, o_words}, 64'(saved_words));
      advance();
      for (int i = 0; i < 10; i++) step(0, 1, 0);

      // test 5: reset pulse at idx 5, FIFO word stays unpopped
      q.push_back(mkword(400));
      for (int i = 0; i < 20 && !(m_have && m_k == 5); i++) step(0, 1, 0);
      q.push_back(mkword(500));
      step(1, 1, 0);
      chk("rst_fifo_kept", 64'(q.size()), 64'd1);
      drive(0, 0, 0);
      @(negedge clk);
      check_model();
      chk("rst_mid_data", {33'd0, o_data}, 64'd0);
      chk("rst_mid_words", {48'd0, o_words}, 64'd0);
      advance();
      for (int i = 0; i < 10; i++) step(0, 1, 0);

      // test 6: 2-bit word counter wraps 1,2,3,0,1
      step(1, 0, 0);
      for (int i = 0; i < 5; i++) q.push_back(mkword(600 + 10 * i));
      last_w = 0;
      for (int i = 0; i < 50; i++) begin
         step(0, 1, 0);
         if (int'(o_words2) != last_w) begin
            last_w = int'(o_words2);
            seq.push_back(last_w);
         end
      end
      chk("wrap_count", 64'(seq.size()), 64'd5);
      for (int i = 0; i < 5 && i < seq.size(); i++)
         chk("wrap_seq", 64'(seq[i]), 64'((i + 1) % 4));

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if (q.size() < 4 && $urandom_range(0, 9) < 4) begin
            nxt = rndword();
            q.push_back(nxt);
         end
         step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 59) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
